insn_encoder_loader: RTL and testbench

Inverse of the instruction decoder. It accepts field-level instruction descriptions (opcode, op, registers, shift, cond, immediate) over a valid/ready handshake and packs each one into a 16-bit instruction word. Packed words are buffered in a small FIFO and written into instruction memory at consecutive addresses. Used by the test/boot path to load programs into the CPU's instruction RAM.

---
 rtl/insn_encoder_loader.sv | 228 ++++++++++++++++++++++
 tb/tb_insn_encoder_loader.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/insn_encoder_loader.sv
// insn_encoder_loader
//
// Packs field-level instruction descriptions into 16-bit instruction words
// and streams them into instruction memory at consecutive addresses. Used by
// the test/boot path to load programs into the CPU's instruction RAM.
//
// Optional build macro: IMM_RANGE_CHECK_EN
//   defined   - immediates that do not fit their sign-extended field
//               (imm5: -16..15, imm8: -128..127) are rejected and raise err
//   undefined - immediates are silently truncated to the field width
//
// Ports:
//   clk, reset_n          clock (rising edge), async active-low reset
//   start, base_addr      begin a load session at base_addr (IDLE only)
//   in_valid, in_ready    tuple handshake
//   opcode..imm           instruction fields
//   flush                 end of program: drain the FIFO, pulse done
//   mem_write, mem_addr,
//   mem_wdata, mem_ack    instruction memory write port (held until ack)
//   busy                  session in progress
//   done                  one-cycle pulse at end of session
//   err                   sticky: a tuple was rejected (cleared by start)
module insn_encoder_loader #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        opcode,
  input  logic [1:0]        op,
  input  logic [2:0]        rd,
  input  logic [2:0]        rn,
  input  logic [2:0]        rm,
  input  logic [1:0]        shift,
  input  logic [2:0]        cond,
  input  logic [15:0]       imm,
  input  logic              flush,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;

  logic [15:0]       fifo_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]     count_q, count_d;

  logic              fifo_empty, fifo_full;
  logic              accept, push, pop;

  logic [15:0]       word;
  logic              legal;
  logic              uses_imm5, uses_imm8;
  logic              range_ok;

  // ---------------------------------------------------------------------------
  // Field encoder
  // ---------------------------------------------------------------------------
  always_comb begin
    word      = '0;
    legal     = 1'b1;
    uses_imm5 = 1'b0;
    uses_imm8 = 1'b0;
    unique case (opcode)
      3'b110: begin
        if (op == 2'b10) begin
          word[10:8] = rd;
          word[7:0]  = imm[7:0];
          uses_imm8  = 1'b1;
        end else if (op == 2'b00) begin
          word[7:5]  = rd;
          word[4:3]  = shift;
          word[2:0]  = rm;
        end else begin
          legal      = 1'b0;
        end
      end
      3'b101: begin
        word[10:8] = rn;
        word[7:5]  = rd;
        word[4:3]  = shift;
        word[2:0]  = rm;
      end
      3'b011, 3'b100: begin
        word[10:8] = rn;
        word[7:5]  = rd;
        word[4:0]  = imm[4:0];
        uses_imm5  = 1'b1;
      end
      3'b001: begin
        word[10:8] = cond;
        word[7:0]  = imm[7:0];
        uses_imm8  = 1'b1;
      end
      3'b010: begin
        if (op == 2'b11) begin
          word[10:8] = rd;
          word[7:0]  = imm[7:0];
          uses_imm8  = 1'b1;
        end else begin
          word[10:8] = rn;
          word[7:5]  = rd;
        end
      end
      3'b111: ;  // HALT: operand bits stay zero
      default: legal = 1'b0;  // opcode 000
    endcase
    word[15:11] = {opcode, op};
  end

`ifdef IMM_RANGE_CHECK_EN
  // In range when all bits above the field's sign bit replicate it.
  assign range_ok = !(uses_imm5 && (imm[15:4] != {12{imm[4]}})) &&
                    !(uses_imm8 && (imm[15:7] != {9{imm[7]}}));
`else
  logic unused_imm;
  assign unused_imm = ^{imm[15:8], uses_imm5, uses_imm8};
  assign range_ok   = 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // Handshake / FIFO control
  // ---------------------------------------------------------------------------
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FullCnt);
  assign accept     = in_valid && in_ready;
  // Rejected tuples still complete the handshake; they just never reach the FIFO.
  assign push       = accept && legal && range_ok;
  assign pop        = !fifo_empty && mem_ack;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: it is only observed through a non-empty count.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= word;
  end

  // ---------------------------------------------------------------------------
  // Session FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
    end
  end

  // Session FSM: next state, address and error flag
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          addr_d  = base_addr;
          err_d   = 1'b0;
        end
      end
      StRun: begin
        if (flush) state_d = StDrain;
      end
      StDrain: begin
        if (fifo_empty) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (accept && !(legal && range_ok)) err_d = 1'b1;
    // Address advances on every accepted write and wraps naturally.
    if (pop) addr_d = addr_q + 1'b1;
  end

  // Session FSM: outputs
  always_comb begin
    in_ready  = (state_q == StRun) && !fifo_full;
    busy      = (state_q != StIdle);
    done      = (state_q == StDone);
    err       = err_q;
    mem_write = !fifo_empty;
    mem_addr  = addr_q;
    mem_wdata = fifo_empty ? 16'h0000 : fifo_q[rd_ptr_q];
  end

endmodule

// File: tb/tb_insn_encoder_loader.sv
module tb_insn_encoder_loader;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [7:0]  base_addr;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  opcode;
  logic [1:0]  op;
  logic [2:0]  rd;
  logic [2:0]  rn;
  logic [2:0]  rm;
  logic [1:0]  shift;
  logic [2:0]  cond;
  logic [15:0] imm;
  logic        flush;
  logic        mem_write;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  insn_encoder_loader #(
    .ADDR_W(8),
    .DEPTH (4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .base_addr (base_addr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .op        (op),
    .rd        (rd),
    .rn        (rn),
    .rm        (rm),
    .shift     (shift),
    .cond      (cond),
    .imm       (imm),
    .flush     (flush),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish, required finish");
    $fatal(1, "simulation timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] b);
    start     = 1'b1;
    base_addr = b;
    tick();
    start     = 1'b0;
  endtask

  // Present one tuple and hold it until the handshake completes (bounded).
  task automatic send(input logic [2:0] o, input logic [1:0] p, input logic [2:0] d,
                      input logic [2:0] n, input logic [2:0] m, input logic [1:0] s,
                      input logic [2:0] c, input logic [15:0] i);
    int w;
    opcode = o; op = p; rd = d; rn = n; rm = m; shift = s; cond = c; imm = i;
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 20) begin
      tick();
      w++;
    end
    chk("send_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for a write, compare it, then acknowledge it.
  task automatic expect_write(input string tag, input logic [7:0] a, input logic [15:0] dat);
    int w;
    w = 0;
    while (!mem_write && w < 10) begin
      tick();
      w++;
    end
    chk({tag, "_wr"}, {31'd0, mem_write}, 32'd1);
    chk({tag, "_addr"}, {24'd0, mem_addr}, {24'd0, a});
    chk({tag, "_data"}, {16'd0, mem_wdata}, {16'd0, dat});
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
  endtask

  task automatic finish_session(input string tag);
    int w;
    flush = 1'b1;
    tick();
    flush   = 1'b0;
    mem_ack = 1'b1;
    w = 0;
    while (!done && w < 20) begin
      tick();
      w++;
    end
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    tick();
    mem_ack = 1'b0;
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_mem_write"}, {31'd0, mem_write}, 32'd0);
    chk({tag, "_mem_addr"}, {24'd0, mem_addr}, 32'd0);
    chk({tag, "_mem_wdata"}, {16'd0, mem_wdata}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; base_addr = '0; in_valid = 1'b0;
    opcode = '0; op = '0; rd = '0; rn = '0; rm = '0; shift = '0; cond = '0; imm = '0;
    flush = 1'b0; mem_ack = 1'b0;
    #12;
    chk_reset_outputs("rst");
    reset_n = 1'b1;
    tick();

    // MOV R2,#5 at 0x10, write appears the cycle after acceptance
    do_start(8'h10);
    chk("run_busy", {31'd0, busy}, 32'd1);
    opcode = 3'b110; op = 2'b10; rd = 3'd2; imm = 16'd5;
    in_valid = 1'b1;
    chk("mov_ready", {31'd0, in_ready}, 32'd1);
    chk("mov_nowrite_yet", {31'd0, mem_write}, 32'd0);
    tick();
    in_valid = 1'b0;
    chk("mov_wr", {31'd0, mem_write}, 32'd1);
    chk("mov_addr", {24'd0, mem_addr}, 32'h10);
    chk("mov_data", {16'd0, mem_wdata}, 32'hD205);
    tick();
    chk("mov_held", {16'd0, mem_wdata}, 32'hD205);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("mov_popped", {31'd0, mem_write}, 32'd0);
    finish_session("s1");

    // ALU, LDR, HALT, then flush with a single done pulse
    do_start(8'h10);
    send(3'b101, 2'b00, 3'd1, 3'd2, 3'd3, 2'b01, 3'd0, 16'd0);
    send(3'b011, 2'b00, 3'd4, 3'd5, 3'd0, 2'b00, 3'd0, 16'hFFFF);
    send(3'b111, 2'b00, 3'd0, 3'd0, 3'd0, 2'b00, 3'd0, 16'd0);
    expect_write("alu", 8'h10, 16'hA22B);
    expect_write("ldr", 8'h11, 16'h659F);
    expect_write("halt", 8'h12, 16'hE000);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("drain_busy", {31'd0, busy}, 32'd1);
    chk("drain_nodone", {31'd0, done}, 32'd0);
    tick();
    chk("done_pulse", {31'd0, done}, 32'd1);
    tick();
    chk("done_once", {31'd0, done}, 32'd0);
    chk("busy_fell", {31'd0, busy}, 32'd0);

    // Backpressure: fill the FIFO with mem_ack low
    do_start(8'h20);
    for (int k = 0; k < 4; k++) begin
      send(3'b110, 2'b10, 3'(k), 3'd0, 3'd0, 2'b00, 3'd0, 16'(k));
    end
    opcode = 3'b110; op = 2'b10; rd = 3'd4; imm = 16'd4;
    in_valid = 1'b1;
    chk("full_refuse", {31'd0, in_ready}, 32'd0);
    chk("full_head", {16'd0, mem_wdata}, 32'hD000);
    tick();
    chk("full_refuse2", {31'd0, in_ready}, 32'd0);
    chk("full_head2", {16'd0, mem_wdata}, 32'hD000);
    mem_ack = 1'b1;
    chk("full_pop_refuse", {31'd0, in_ready}, 32'd0);
    chk("bp_addr0", {24'd0, mem_addr}, 32'h20);
    tick();
    chk("bp_ready_again", {31'd0, in_ready}, 32'd1);
    chk("bp_data1", {16'd0, mem_wdata}, 32'hD101);
    chk("bp_addr1", {24'd0, mem_addr}, 32'h21);
    tick();
    in_valid = 1'b0;
    for (int k = 2; k < 5; k++) begin
      chk("bp_wr", {31'd0, mem_write}, 32'd1);
      chk("bp_data", {16'd0, mem_wdata}, 32'hD000 | (k << 8) | k);
      chk("bp_addr", {24'd0, mem_addr}, 32'h20 + k);
      tick();
    end
    mem_ack = 1'b0;
    chk("bp_empty", {31'd0, mem_write}, 32'd0);
    finish_session("s3");

    // Address wrap from 0xFF to 0x00
    do_start(8'hFF);
    send(3'b110, 2'b10, 3'd1, 3'd0, 3'd0, 2'b00, 3'd0, 16'd1);
    send(3'b111, 2'b00, 3'd0, 3'd0, 3'd0, 2'b00, 3'd0, 16'd0);
    expect_write("wrap0", 8'hFF, 16'hD101);
    expect_write("wrap1", 8'h00, 16'hE000);
    finish_session("s4");

    // Illegal tuples and immediate range
    do_start(8'h40);
    chk("err_clear", {31'd0, err}, 32'd0);
    send(3'b000, 2'b00, 3'd1, 3'd1, 3'd1, 2'b00, 3'd0, 16'd0);
    chk("ill_err", {31'd0, err}, 32'd1);
    chk("ill_nowrite", {31'd0, mem_write}, 32'd0);
    send(3'b110, 2'b01, 3'd1, 3'd0, 3'd0, 2'b00, 3'd0, 16'd0);
    chk("ill2_nowrite", {31'd0, mem_write}, 32'd0);
    send(3'b001, 2'b00, 3'd0, 3'd0, 3'd0, 2'b00, 3'd0, 16'd200);
`ifdef IMM_RANGE_CHECK_EN
    chk("range_nowrite", {31'd0, mem_write}, 32'd0);
    send(3'b111, 2'b00, 3'd0, 3'd0, 3'd0, 2'b00, 3'd0, 16'd0);
    expect_write("after_ill", 8'h40, 16'hE000);
`else
    expect_write("br_trunc", 8'h40, 16'h20C8);
    send(3'b111, 2'b00, 3'd0, 3'd0, 3'd0, 2'b00, 3'd0, 16'd0);
    expect_write("after_ill", 8'h41, 16'hE000);
`endif
    chk("err_sticky", {31'd0, err}, 32'd1);
    finish_session("s5");
    chk("err_sticky_idle", {31'd0, err}, 32'd1);

    // Reset in the middle of DRAIN with two words buffered
    do_start(8'h50);
    chk("err_cleared_by_start", {31'd0, err}, 32'd0);
    send(3'b110, 2'b10, 3'd1, 3'd0, 3'd0, 2'b00, 3'd0, 16'd1);
    send(3'b110, 2'b10, 3'd2, 3'd0, 3'd0, 2'b00, 3'd0, 16'd2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    chk("pre_rst_wr", {31'd0, mem_write}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    #3;
    reset_n = 1'b1;
    tick();
    do_start(8'h60);
    chk("post_rst_nostale", {31'd0, mem_write}, 32'd0);
    send(3'b110, 2'b10, 3'd3, 3'd0, 3'd0, 2'b00, 3'd0, 16'd7);
    expect_write("post_rst", 8'h60, 16'hD307);
    chk("post_rst_empty", {31'd0, mem_write}, 32'd0);
    finish_session("s6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
